// File: rtl/edge_event_monitor_pkg.sv
// Shared constants and helpers for the edge event monitor.
// Imported by the channel slice and the top level.
package edge_event_monitor_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // A single channel still needs a one-bit select.
    function automatic int sel_width(input int ch);
        return (clog2(ch) < 1) ? 1 : clog2(ch);
    endfunction

endpackage

// File: rtl/edge_event_channel.sv
// One monitored channel: optional synchronizer, edge detector, counter, ovf.
// EDGE_MONITOR_SYNC_EN adds a two-flop input synchronizer.
module edge_event_channel
    import edge_event_monitor_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int EDGE_MODE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             h,
    input  logic             primed,
    input  logic             clear,
    output logic             i,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             ovf
);

    logic             h_s;
    logic             h_q;
    logic             rise;
    logic             fall;
    logic             ev;
    logic             ovf_nxt;
    logic [CNT_W-1:0] cnt;

`ifdef EDGE_MONITOR_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], h};
        end
    end

    assign h_s = sync[1];
`else
    assign h_s = h;
`endif

    assign rise = h_s & ~h_q;
    assign fall = ~h_s & h_q;

    always_comb begin
        ev = 1'b0;
        case (EDGE_MODE)
            EDGE_FALL: ev = fall;
            EDGE_BOTH: ev = rise | fall;
            default:   ev = rise;
        endcase
        ev = ev & primed;
    end

    // Clear wins over a coincident event for counting only.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (clear) begin
            cnt_nxt = '0;
            ovf_nxt = 1'b0;
        end else if (ev) begin
            cnt_nxt = cnt + CNT_W'(1);
            if (&cnt) begin
                ovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_q <= 1'b0;
            i   <= 1'b0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            h_q <= h_s;
            i   <= ev;
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
        end
    end

endmodule

// File: rtl/edge_event_monitor.sv
// Multi-channel edge event monitor: priming, channel array, count readout.
// EDGE_MONITOR_SYNC_EN synchronizes inputs and extends the priming window.
module edge_event_monitor
    import edge_event_monitor_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 8,
    parameter int EDGE_MODE = EDGE_RISE,
    parameter int SEL_W     = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [CHANNELS-1:0] h,
    input  logic                clear,
    input  logic [SEL_W-1:0]    sel,
    output logic [CHANNELS-1:0] i,
    output logic [CNT_W-1:0]    count_o,
    output logic [CHANNELS-1:0] ovf
);

    if (SEL_W != sel_width(CHANNELS)) begin : g_bad_sel
        $error("SEL_W must equal clog2(CHANNELS)");
    end

    if (EDGE_MODE > EDGE_BOTH || EDGE_MODE < EDGE_RISE) begin : g_bad_mode
        $error("EDGE_MODE must be 0, 1 or 2");
    end

    logic             primed;
    logic [CNT_W-1:0] cnt_nxt [CHANNELS];
    logic [CNT_W-1:0] count_d;

`ifdef EDGE_MONITOR_SYNC_EN
    // Three edges flush the synchronizer and load h_q before counting.
    logic [1:0] prime_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prime_cnt <= 2'd0;
        end else if (prime_cnt != 2'd3) begin
            prime_cnt <= prime_cnt + 2'd1;
        end
    end

    assign primed = (prime_cnt == 2'd3);
`else
    logic primed_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            primed_q <= 1'b0;
        end else begin
            primed_q <= 1'b1;
        end
    end

    assign primed = primed_q;
`endif

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        edge_event_channel #(
            .CNT_W     (CNT_W),
            .EDGE_MODE (EDGE_MODE)
        ) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .h       (h[n]),
            .primed  (primed),
            .clear   (clear),
            .i       (i[n]),
            .cnt_nxt (cnt_nxt[n]),
            .ovf     (ovf[n])
        );
    end

    // Out-of-range selects match no channel and read as zero.
    always_comb begin
        count_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k)) begin
                count_d = cnt_nxt[k];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_o <= '0;
        end else begin
            count_o <= count_d;
        end
    end

endmodule

// File: tb/tb_edge_event_monitor.sv
// Bench for edge_event_monitor: three DUTs (rise/fall/both) share stimulus.
// A queue-based reference model tracks events, counts and overflow flags.
module tb_edge_event_monitor;

`ifdef EDGE_MONITOR_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif
    localparam int PRIME = DLY + 1;

    logic       clk    = 1'b0;
    logic       resetn = 1'b1;
    logic       clear  = 1'b0;
    logic [3:0] h      = 4'h0;
    logic [1:0] sel    = 2'd0;

    logic [3:0] i_o   [3];
    logic [3:0] cnt_o [3];
    logic [3:0] ovf_o [3];

    int errors = 0;
    int checks = 0;

    int         m_cnt [3][4];
    logic [3:0] m_ovf [3];
    logic [3:0] m_i   [3];
    logic [3:0] m_co  [3];
    logic [3:0] prev_hs;
    logic [3:0] hq [$];
    int         edges;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        edge_event_monitor #(
            .CHANNELS  (4),
            .CNT_W     (4),
            .EDGE_MODE (m),
            .SEL_W     (2)
        ) u_dut (
            .clk     (clk),
            .resetn  (resetn),
            .h       (h),
            .clear   (clear),
            .sel     (sel),
            .i       (i_o[m]),
            .count_o (cnt_o[m]),
            .ovf     (ovf_o[m])
        );
    end

    task automatic reset_model();
        hq.delete();
        prev_hs = 4'h0;
        edges   = 0;
        for (int m = 0; m < 3; m++) begin
            m_ovf[m] = 4'h0;
            m_i[m]   = 4'h0;
            m_co[m]  = 4'h0;
            for (int n = 0; n < 4; n++) m_cnt[m][n] = 0;
        end
    endtask

    // One clock edge of the reference model, from the current inputs.
    task automatic model_edge();
        logic [3:0] hs;
        bit primed, r, f, ev;
        hq.push_back(h);
        if (hq.size() > DLY) hs = hq.pop_front();
        else hs = 4'h0;
        primed = (edges >= PRIME);
        for (int m = 0; m < 3; m++) begin
            for (int n = 0; n < 4; n++) begin
                r  = hs[n] && !prev_hs[n];
                f  = !hs[n] && prev_hs[n];
                ev = primed && ((m == 0 && r) || (m == 1 && f) ||
                                (m == 2 && (r || f)));
                m_i[m][n] = ev;
                if (clear) begin
                    m_cnt[m][n] = 0;
                    m_ovf[m][n] = 1'b0;
                end else if (ev) begin
                    if (m_cnt[m][n] == 15) m_ovf[m][n] = 1'b1;
                    m_cnt[m][n] = (m_cnt[m][n] + 1) % 16;
                end
            end
            m_co[m] = 4'(m_cnt[m][sel]);
        end
        prev_hs = hs;
        edges++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetn === 1'b1) model_edge();
        #1;
    endtask

    task automatic test_reset();
        h = 4'hF;
        #1 resetn = 1'b0;
        reset_model();
        #11;
        for (int m = 0; m < 3; m++) begin
            checks += 3;
            if (i_o[m] !== 4'h0) begin
                errors++; $display("FAIL reset_i m%0d got %b exp 0000", m, i_o[m]);
            end
            if (cnt_o[m] !== 4'h0) begin
                errors++; $display("FAIL reset_cnt m%0d got %0d exp 0", m, cnt_o[m]);
            end
            if (ovf_o[m] !== 4'h0) begin
                errors++; $display("FAIL reset_ovf m%0d got %b exp 0000", m, ovf_o[m]);
            end
        end
        @(posedge clk);
        #2 resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int m = 0; m < 3; m++) begin
                checks += 3;
                if (i_o[m] !== 4'h0) begin
                    errors++; $display("FAIL idle_i m%0d c%0d got %b exp 0000", m, c, i_o[m]);
                end
                if (cnt_o[m] !== 4'h0) begin
                    errors++; $display("FAIL idle_cnt m%0d c%0d got %0d exp 0", m, c, cnt_o[m]);
                end
                if (ovf_o[m] !== 4'h0) begin
                    errors++; $display("FAIL idle_ovf m%0d c%0d got %b exp 0000", m, c, ovf_o[m]);
                end
            end
        end
    endtask

    task automatic test_toggle_ch2();
        sel = 2'd2;
        h   = 4'h0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int t = 0; t < 3; t++) begin
            h[2] = 1'b1;
            repeat (DLY) tick();
            tick();
            checks++;
            if (i_o[0] !== 4'b0100) begin
                errors++; $display("FAIL tog_rise t%0d got %b exp 0100", t, i_o[0]);
            end
            tick();
            checks++;
            if (i_o[0] !== 4'b0000) begin
                errors++; $display("FAIL tog_hold t%0d got %b exp 0000", t, i_o[0]);
            end
            h[2] = 1'b0;
            repeat (DLY) tick();
            tick();
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (i_o[m] !== m_i[m]) begin
                    errors++; $display("FAIL tog_fall m%0d got %b exp %b", m, i_o[m], m_i[m]);
                end
            end
            tick();
        end
        checks += 3;
        if (cnt_o[0] !== 4'd3) begin
            errors++; $display("FAIL tog_count got %0d exp 3", cnt_o[0]);
        end
        if (cnt_o[1] !== 4'd3) begin
            errors++; $display("FAIL tog_count_fall got %0d exp 3", cnt_o[1]);
        end
        if (cnt_o[2] !== 4'd6) begin
            errors++; $display("FAIL tog_count_both got %0d exp 6", cnt_o[2]);
        end
    endtask

    task automatic test_wrap();
        sel = 2'd0;
        h   = 4'h0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 1; k <= 17 + DLY; k++) begin
            if (k <= 17) h[0] = ~h[0];
            tick();
            checks += 2;
            if (i_o[2][0] !== 1'b1 && k > DLY) begin
                errors++; $display("FAIL wrap_pulse k%0d got %b exp 1", k, i_o[2][0]);
            end
            if (cnt_o[2] !== m_co[2]) begin
                errors++; $display("FAIL wrap_model k%0d got %0d exp %0d", k, cnt_o[2], m_co[2]);
            end
            if (k == 16 + DLY) begin
                checks += 2;
                if (cnt_o[2] !== 4'd0) begin
                    errors++; $display("FAIL wrap_zero got %0d exp 0", cnt_o[2]);
                end
                if (ovf_o[2][0] !== 1'b1) begin
                    errors++; $display("FAIL wrap_ovf got %b exp 1", ovf_o[2][0]);
                end
            end
        end
        tick();
        checks += 4;
        if (cnt_o[2] !== 4'd1) begin
            errors++; $display("FAIL wrap_final got %0d exp 1", cnt_o[2]);
        end
        if (ovf_o[2][0] !== 1'b1) begin
            errors++; $display("FAIL wrap_sticky got %b exp 1", ovf_o[2][0]);
        end
        if (cnt_o[0] !== 4'd9 || ovf_o[0][0] !== 1'b0) begin
            errors++; $display("FAIL wrap_rise got %0d/%b exp 9/0", cnt_o[0], ovf_o[0][0]);
        end
        if (cnt_o[1] !== 4'd8) begin
            errors++; $display("FAIL wrap_fall got %0d exp 8", cnt_o[1]);
        end
    endtask

    task automatic test_clear();
        sel = 2'd1;
        h   = 4'h0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int p = 0; p < 5; p++) begin
            h[1] = 1'b1;
            tick();
            h[1] = 1'b0;
            tick();
        end
        repeat (DLY) tick();
        checks++;
        if (cnt_o[0] !== 4'd5) begin
            errors++; $display("FAIL clr_pre got %0d exp 5", cnt_o[0]);
        end
        h[1] = 1'b1;
        repeat (DLY) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks += 3;
        if (i_o[0][1] !== 1'b1) begin
            errors++; $display("FAIL clr_pulse got %b exp 1", i_o[0][1]);
        end
        if (cnt_o[0] !== 4'd0) begin
            errors++; $display("FAIL clr_cnt got %0d exp 0", cnt_o[0]);
        end
        if (ovf_o[0][1] !== 1'b0) begin
            errors++; $display("FAIL clr_ovf got %b exp 0", ovf_o[0][1]);
        end
        h[1] = 1'b0;
        tick();
        h[1] = 1'b1;
        repeat (DLY + 1) tick();
        checks++;
        if (cnt_o[0] !== 4'd1) begin
            errors++; $display("FAIL clr_next got %0d exp 1", cnt_o[0]);
        end
    endtask

    task automatic test_mid_reset();
        sel = 2'd3;
        h   = 4'h0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int p = 0; p < 7; p++) begin
            h[3] = 1'b1;
            tick();
            h[3] = 1'b0;
            tick();
        end
        repeat (DLY) tick();
        checks++;
        if (cnt_o[0] !== 4'd7) begin
            errors++; $display("FAIL mid_pre got %0d exp 7", cnt_o[0]);
        end
        #3 resetn = 1'b0;
        reset_model();
        h[3] = 1'b1;
        #1;
        for (int m = 0; m < 3; m++) begin
            checks += 2;
            if (cnt_o[m] !== 4'h0) begin
                errors++; $display("FAIL mid_async_cnt m%0d got %0d exp 0", m, cnt_o[m]);
            end
            if (ovf_o[m] !== 4'h0) begin
                errors++; $display("FAIL mid_async_ovf m%0d got %b exp 0000", m, ovf_o[m]);
            end
        end
        @(posedge clk);
        #2 resetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int m = 0; m < 3; m++) begin
                checks += 2;
                if (i_o[m] !== 4'h0) begin
                    errors++; $display("FAIL mid_rel_i m%0d c%0d got %b exp 0000", m, c, i_o[m]);
                end
                if (cnt_o[m] !== 4'h0) begin
                    errors++; $display("FAIL mid_rel_cnt m%0d c%0d got %0d exp 0", m, c, cnt_o[m]);
                end
            end
        end
    endtask

    task automatic test_latency();
        int found;
        sel = 2'd0;
        h   = 4'h0;
        repeat (2) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (6) tick();
        h[0]  = 1'b1;
        found = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (i_o[0][0] === 1'b1) begin
                found = k;
                break;
            end
        end
        checks += 3;
        if (found != 1 + DLY) begin
            errors++; $display("FAIL lat_edges got %0d exp %0d", found, 1 + DLY);
        end
        if (cnt_o[0] !== 4'd1) begin
            errors++; $display("FAIL lat_count got %0d exp 1", cnt_o[0]);
        end
        tick();
        if (i_o[0][0] !== 1'b0 || cnt_o[0] !== 4'd1) begin
            errors++; $display("FAIL lat_once got %b/%0d exp 0/1", i_o[0][0], cnt_o[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            h     = 4'($urandom);
            clear = ($urandom_range(0, 15) == 0);
            sel   = 2'($urandom_range(0, 3));
            tick();
            for (int m = 0; m < 3; m++) begin
                checks += 3;
                if (i_o[m] !== m_i[m]) begin
                    errors++; $display("FAIL rand_i m%0d c%0d got %b exp %b", m, c, i_o[m], m_i[m]);
                end
                if (cnt_o[m] !== m_co[m]) begin
                    errors++; $display("FAIL rand_cnt m%0d c%0d got %0d exp %0d", m, c, cnt_o[m], m_co[m]);
                end
                if (ovf_o[m] !== m_ovf[m]) begin
                    errors++; $display("FAIL rand_ovf m%0d c%0d got %b exp %b", m, c, ovf_o[m], m_ovf[m]);
                end
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        reset_model();
        test_reset();
        test_toggle_ch2();
        test_wrap();
        test_clear();
        test_mid_reset();
        test_latency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_event_monitor.md
Name: edge_event_monitor

Overview:
- Multi-channel, parametrised signal-test block.
- Samples CHANNELS single-bit test inputs, detects the configured edge on each, and emits a one-cycle event pulse per channel.
- Keeps a per-channel event counter with a sticky overflow flag.
- Exposes one selected channel's count for readout; sits between the design-under-test signal taps and the board/bench observation logic.

Parameters:
- CHANNELS, 4, number of independent monitored inputs (1..16).
- CNT_W, 8, width of each per-channel event counter (2..16).
- EDGE_MODE, 0, edge qualifying an event: 0 = rising, 1 = falling, 2 = both.
- SEL_W, 2, width of the channel select; must equal clog2(CHANNELS), minimum 1.

Ports:
- clk  input  1  single system clock, rising-edge active.
- resetn  input  1  asynchronous, active-low reset.
- h  input  CHANNELS  monitored test inputs, one bit per channel.
- clear  input  1  synchronous clear of all counters and overflow flags.
- sel  input  SEL_W  channel whose count is driven on count_o.
- i  output  CHANNELS  registered one-cycle event pulse per channel.
- count_o  output  CNT_W  registered count of channel sel.
- ovf  output  CHANNELS  sticky per-channel counter overflow flag.

Behaviour:
- Reset (resetn low, asynchronous): h_q, i, all counters, count_o and ovf go to 0 immediately. They stay 0 while resetn is low.
- Reset release: the first rising clk edge with resetn high samples h into h_q only. It never produces an event, whatever the level of h. A per-module "primed" flag, cleared by reset and set by this first edge, enforces it.
- Per channel n at each rising clk edge (primed):
  - rise = h[n] & ~h_q[n]; fall = ~h[n] & h_q[n].
  - ev = rise (mode 0), fall (mode 1), or rise | fall (mode 2).
  - h_q[n] <= h[n]; i[n] <= ev.
- Latency: i[n] is high for exactly the one cycle following the sampling edge that saw the transition. A level held high produces one pulse only.
- Counter n, same edge, with clear = 0:
  - ev = 1: cnt[n] <= cnt[n] + 1, modulo 2^CNT_W.
  - ev = 1 and cnt[n] is all-ones: cnt[n] wraps to 0 and ovf[n] <= 1.
- ovf[n] is sticky until clear or reset.
- clear = 1 at an edge:
  - All cnt and ovf go to 0 that edge.
  - A simultaneous ev is discarded for counting (clear wins), but i[n] still pulses.
  - h_q is still updated.
- count_o <= cnt[sel] as updated this edge, so count_o reflects the post-update value one cycle after the edge. A change on sel is visible on count_o at the next edge.
- sel >= CHANNELS: count_o <= 0.
- Reset mid-operation: counts are lost, and the first post-reset edge is non-counting per the reset-release rule.

Optional Feature:
- Macro: EDGE_MONITOR_SYNC_EN.
- Defined: each h bit passes through a two-flop synchronizer, reset to 0, before edge detection. Event latency grows by 2 cycles. The primed flag is set only after 3 edges following reset release, so synchronizer flush values never count.
- Undefined: h feeds edge detection directly. h must be synchronous to clk; latency is as stated above.

Decomposition:
- Shared package/include header:
  - edge-mode constants EDGE_RISE = 0, EDGE_FALL = 1, EDGE_BOTH = 2;
  - a clog2 constant function for SEL_W checking.
- One natural sub-module, edge_event_channel: one channel's synchronizer (under macro), edge detector, counter and ovf flag. It is instantiated CHANNELS times via generate.
- The top level holds the primed flag, clear fan-out and the count_o mux.

Test Plan:
- Configuration for all scenarios: CHANNELS = 4, CNT_W = 4, macro undefined, unless stated otherwise.
- Reset then idle: resetn low with h = 4'b1111, then release.
  - Expect i = 0, count_o = 0, ovf = 0 for all cycles.
  - No event on the priming edge.
- EDGE_MODE = 0, channel 2 toggled 0→1→0 three times, sel = 2.
  - Expect three single-cycle pulses on i[2] only.
  - count_o ends at 3; i[2] is never high on falling edges.
- EDGE_MODE = 2, 17 toggles on channel 0 (9 rising, 8 falling), sel = 0.
  - At the 16th event, count wraps to 0 and ovf[0] goes to 1.
  - Final count_o = 1; ovf[0] stays 1.
- clear asserted on the same edge as a rising event on channel 1 with cnt[1] = 5, sel = 1.
  - i[1] pulses; next cycle count_o = 0 and ovf[1] = 0.
  - The next rising event gives count_o = 1.
- Mid-count reset: cnt[3] = 7, pulse resetn low between edges.
  - count_o and ovf drop to 0 asynchronously, without waiting for a clock edge.
  - h[3] held high across release produces no event.
- Macro defined, rising edge on h[0] at cycle 10 after priming.
  - i[0] is high exactly 2 cycles later than in the undefined build; count increments once.
